// File: rtl/codec_if_param_if.sv
// Codec-side signal bundle for codec_if_param: serial lines, codec clocks and
// the parallel sample ports. master = the interface block, slave = its user/codec.
interface codec_if_param_if #(
   parameter int DATA_W = 16
);
   logic              SD_out;
   logic [DATA_W-1:0] left_out;
   logic [DATA_W-1:0] right_out;
   logic              MCLK;
   logic              SCLK;
   logic              LRCLK;
   logic              RST_n;
   logic              SD_in;
   logic [DATA_W-1:0] left_in;
   logic [DATA_W-1:0] right_in;
   logic              VALID;

   modport master (
      input  SD_out, left_out, right_out,
      output MCLK, SCLK, LRCLK, RST_n, SD_in, left_in, right_in, VALID
   );

   modport slave (
      output SD_out, left_out, right_out,
      input  MCLK, SCLK, LRCLK, RST_n, SD_in, left_in, right_in, VALID
   );
endinterface

// File: rtl/codec_if_param.sv
// Audio codec serial interface (I2S or left-justified) with codec start-up sequencing.
// Optional feature macro CODEC_LOOPBACK_EN adds the lpbk port (rx samples fed back to tx).

module codec_if_param_chk (
   input logic       clk,
   input logic       rst_n,
   input logic [9:0] cnt,
   input logic [1:0] state,
   input logic       mclk,
   input logic       sclk,
   input logic       lrclk,
   input logic       rst_codec,
   input logic       valid,
   input logic       sd_in
);
   localparam logic [1:0] ST_HOLD = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd2;

   a_mclk: assert property (@(posedge clk) disable iff (!rst_n) mclk == cnt[1]);
   a_sclk: assert property (@(posedge clk) disable iff (!rst_n) sclk == cnt[3]);
   a_lrclk: assert property (@(posedge clk) disable iff (!rst_n) lrclk == cnt[9]);
   a_valid: assert property (@(posedge clk) disable iff (!rst_n)
      valid == ((cnt == 10'd1023) && (state == ST_RUN)));
   a_run_sticky: assert property (@(posedge clk) disable iff (!rst_n)
      (state == ST_RUN) |=> (state == ST_RUN));
   a_rst_codec: assert property (@(posedge clk) disable iff (!rst_n)
      rst_codec == (state != ST_HOLD));
   // Serial DAC data may only move on the SCLK falling boundary.
   a_sd_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (cnt[3:0] != 4'h0) |-> $stable(sd_in));
endmodule

module codec_if_param #(
   parameter int DATA_W = 16,
   parameter int FMT    = 0
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef CODEC_LOOPBACK_EN
   input  logic             lpbk,
`endif
   codec_if_param_if.master bus
);

   typedef enum logic [1:0] {
      HOLD = 2'd0,
      WARM = 2'd1,
      RUN  = 2'd2
   } state_t;

   // I2S puts the MSB one slot after the LRCLK edge; left-justified puts it on the edge.
   localparam logic [5:0]        SLOT_OFF = (FMT == 0) ? 6'd1 : 6'd0;
   localparam logic [5:0]        DW6      = 6'(DATA_W);
   localparam logic [DATA_W-1:0] MSB_ONE  = {1'b1, {(DATA_W-1){1'b0}}};

   state_t            state_r;
   logic [9:0]        cnt_r;
   logic [9:0]        cnt_nxt_s;
   logic              mclk_r;
   logic              sclk_r;
   logic              lrclk_r;
   logic              rst_codec_r;
   logic              valid_r;
   logic              sd_in_r;
   logic [DATA_W-1:0] rx_l_r;
   logic [DATA_W-1:0] rx_r_r;
   logic [DATA_W-1:0] left_in_r;
   logic [DATA_W-1:0] right_in_r;
   logic [DATA_W-1:0] tx_l_r;
   logic [DATA_W-1:0] tx_r_r;
   logic [DATA_W-1:0] src_l_s;
   logic [DATA_W-1:0] src_r_s;
   logic [DATA_W-1:0] tx_l_nxt_s;
   logic [DATA_W-1:0] tx_r_nxt_s;
   logic [DATA_W-1:0] tx_word_s;
   logic [5:0]        tx_pos_s;
   logic [5:0]        rx_pos_s;
   logic              sd_bit_s;
   logic              rx_take_s;
   logic              wrap_s;
   logic              valid_set_s;

   // Frame timing decode shared by the sequential blocks.
   always_comb begin
      cnt_nxt_s   = cnt_r + 10'd1;
      wrap_s      = (cnt_r == 10'd1023);
      valid_set_s = (state_r == RUN) && (cnt_r == 10'd1022);
      rx_pos_s    = {1'b0, cnt_r[8:4]} - SLOT_OFF;
      rx_take_s   = (cnt_r[3:0] == 4'h7) && (rx_pos_s < DW6);
   end

   // Transmit source: parallel inputs, or the freshly received frame in loopback.
   always_comb begin
      src_l_s = bus.left_out;
      src_r_s = bus.right_out;
`ifdef CODEC_LOOPBACK_EN
      if (lpbk) begin
         src_l_s = left_in_r;
         src_r_s = right_in_r;
      end else begin
         src_l_s = bus.left_out;
         src_r_s = bus.right_out;
      end
`endif
   end

   // Next tx latch contents and the DAC bit for the slot that starts at the next edge.
   always_comb begin
      tx_l_nxt_s = tx_l_r;
      tx_r_nxt_s = tx_r_r;
      if (valid_r) begin
         tx_l_nxt_s = src_l_s;
         tx_r_nxt_s = src_r_s;
      end else begin
         tx_l_nxt_s = tx_l_r;
         tx_r_nxt_s = tx_r_r;
      end
      // The tx latch loads on the same edge that opens slot 0, so use the next value.
      tx_pos_s  = {1'b0, cnt_nxt_s[8:4]} - SLOT_OFF;
      tx_word_s = cnt_nxt_s[9] ? tx_r_nxt_s : tx_l_nxt_s;
      if (tx_pos_s < DW6) begin
         sd_bit_s = |(tx_word_s & (MSB_ONE >> tx_pos_s));
      end else begin
         sd_bit_s = 1'b0;
      end
   end

   // Free-running frame counter and the derived codec clocks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r   <= 10'd0;
         mclk_r  <= 1'b0;
         sclk_r  <= 1'b0;
         lrclk_r <= 1'b0;
      end else begin
         cnt_r   <= cnt_nxt_s;
         mclk_r  <= cnt_nxt_s[1];
         sclk_r  <= cnt_nxt_s[3];
         lrclk_r <= cnt_nxt_s[9];
      end
   end

   // Start-up sequencer: hold codec in reset one frame, let it warm up one frame, then run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= HOLD;
         rst_codec_r <= 1'b0;
         valid_r     <= 1'b0;
      end else begin
         valid_r <= valid_set_s;
         case (state_r)
            HOLD: begin
               if (wrap_s) begin
                  state_r     <= WARM;
                  rst_codec_r <= 1'b1;
               end else begin
                  state_r     <= HOLD;
                  rst_codec_r <= 1'b0;
               end
            end
            WARM: begin
               rst_codec_r <= 1'b1;
               if (wrap_s) begin
                  state_r <= RUN;
               end else begin
                  state_r <= WARM;
               end
            end
            RUN: begin
               state_r     <= RUN;
               rst_codec_r <= 1'b1;
            end
            default: begin
               state_r     <= HOLD;
               rst_codec_r <= 1'b0;
            end
         endcase
      end
   end

   // ADC capture on SCLK rise into per-channel shift registers; publish with VALID.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_l_r     <= '0;
         rx_r_r     <= '0;
         left_in_r  <= '0;
         right_in_r <= '0;
      end else begin
         if (rx_take_s && !cnt_r[9]) begin
            rx_l_r <= {rx_l_r[DATA_W-2:0], bus.SD_out};
         end
         if (rx_take_s && cnt_r[9]) begin
            rx_r_r <= {rx_r_r[DATA_W-2:0], bus.SD_out};
         end
         if (valid_set_s) begin
            left_in_r  <= rx_l_r;
            right_in_r <= rx_r_r;
         end
      end
   end

   // DAC side: tx latch loads at the end of the VALID cycle; SD_in moves on SCLK fall only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_l_r  <= '0;
         tx_r_r  <= '0;
         sd_in_r <= 1'b0;
      end else begin
         tx_l_r <= tx_l_nxt_s;
         tx_r_r <= tx_r_nxt_s;
         if (cnt_r[3:0] == 4'hF) begin
            sd_in_r <= sd_bit_s;
         end
      end
   end

   assign bus.MCLK     = mclk_r;
   assign bus.SCLK     = sclk_r;
   assign bus.LRCLK    = lrclk_r;
   assign bus.RST_n    = rst_codec_r;
   assign bus.SD_in    = sd_in_r;
   assign bus.left_in  = left_in_r;
   assign bus.right_in = right_in_r;
   assign bus.VALID    = valid_r;

   codec_if_param_chk u_chk (
      .clk       (clk),
      .rst_n     (rst_n),
      .cnt       (cnt_r),
      .state     (state_r),
      .mclk      (mclk_r),
      .sclk      (sclk_r),
      .lrclk     (lrclk_r),
      .rst_codec (rst_codec_r),
      .valid     (valid_r),
      .sd_in     (sd_in_r)
   );

endmodule

// File: tb/tb_codec_if_param.sv
// Directed bench for codec_if_param: an I2S 16-bit instance and a left-justified 24-bit instance.
module tb_codec_if_param;

   logic clk;
   logic rst_n;
`ifdef CODEC_LOOPBACK_EN
   logic lpbk;
`endif
   int   e;
   int   total;
   int   passed;
   int   fails;
   logic [31:0] cap0la, cap0lb, cap0r, cap1l, cap1r;

   codec_if_param_if #(.DATA_W(16)) bus0 ();
   codec_if_param_if #(.DATA_W(24)) bus1 ();

   codec_if_param #(.DATA_W(16), .FMT(0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef CODEC_LOOPBACK_EN
      .lpbk  (lpbk),
`endif
      .bus   (bus0)
   );

   codec_if_param #(.DATA_W(24), .FMT(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef CODEC_LOOPBACK_EN
      .lpbk  (lpbk),
`endif
      .bus   (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      e = e + 1;
      @(negedge clk);
   endtask

   task automatic adv_to(input int t);
      while (e < t) tick();
   endtask

   // One full frame starting at cnt 0: codec model drives SD_out, SD_in is captured per slot.
   task automatic run_frame();
      logic [15:0] w0;
      logic [23:0] w1;
      int          si;
      logic        ch;
      cap0la = '0; cap0lb = '0; cap0r = '0; cap1l = '0; cap1r = '0;
      for (int c = 0; c < 1024; c++) begin
         si = (c % 512) / 16;
         ch = (c >= 512);
         if ((c % 16) == 0) begin
            w0 = ch ? 16'h0001 : 16'hA5C3;
            w1 = ch ? 24'hC30F81 : 24'h5A5A5A;
            bus0.SD_out = (si >= 1 && si <= 16) ? w0[4'(16 - si)] : 1'b0;
            bus1.SD_out = (si <= 23) ? w1[5'(23 - si)] : 1'b0;
         end
         if ((c % 16) == 1) begin
            if (!ch) begin
               cap0la = {cap0la[30:0], bus0.SD_in};
               cap1l  = {cap1l[30:0], bus1.SD_in};
            end else begin
               cap0r = {cap0r[30:0], bus0.SD_in};
               cap1r = {cap1r[30:0], bus1.SD_in};
            end
         end
         if ((c % 16) == 15 && !ch) cap0lb = {cap0lb[30:0], bus0.SD_in};
         if (c != 1023) tick();
      end
   endtask

   initial begin
      total = 0; passed = 0; fails = 0; e = 0;
      rst_n = 1'b0;
`ifdef CODEC_LOOPBACK_EN
      lpbk = 1'b0;
`endif
      bus0.SD_out = 1'b0;
      bus1.SD_out = 1'b0;
      bus0.left_out = 16'hA5C3;   bus0.right_out = 16'h0001;
      bus1.left_out = 24'h800001; bus1.right_out = 24'h400002;
      repeat (3) @(negedge clk);

      chk("rst_outs0", 32'({bus0.MCLK, bus0.SCLK, bus0.LRCLK, bus0.RST_n, bus0.SD_in, bus0.VALID}), 32'h0);
      chk("rst_left_in0", 32'(bus0.left_in), 32'h0);
      chk("rst_right_in0", 32'(bus0.right_in), 32'h0);
      chk("rst_outs1", 32'({bus1.MCLK, bus1.SCLK, bus1.LRCLK, bus1.RST_n, bus1.SD_in, bus1.VALID}), 32'h0);

      rst_n = 1'b1;
      e = 0;
      adv_to(1);    chk("mclk_e1", 32'(bus0.MCLK), 32'h0);
      adv_to(2);    chk("mclk_e2", 32'(bus0.MCLK), 32'h1);
      adv_to(4);    chk("mclk_e4", 32'(bus0.MCLK), 32'h0);
      adv_to(7);    chk("sclk_e7", 32'(bus0.SCLK), 32'h0);
      adv_to(8);    chk("sclk_e8", 32'(bus0.SCLK), 32'h1);
      adv_to(16);   chk("sclk_e16", 32'(bus0.SCLK), 32'h0);
      adv_to(511);  chk("lrclk_e511", 32'(bus0.LRCLK), 32'h0);
      adv_to(512);  chk("lrclk_e512", 32'(bus0.LRCLK), 32'h1);
      adv_to(1023); chk("rst_codec_e1023", 32'(bus0.RST_n), 32'h0);
      adv_to(1024); chk("rst_codec_e1024", 32'(bus0.RST_n), 32'h1);
      chk("lrclk_e1024", 32'(bus0.LRCLK), 32'h0);

      while (bus0.VALID !== 1'b1 && e < 5000) tick();
      chk("first_valid_clk", 32'(e), 32'd3071);
      chk("first_valid_dut1", 32'(bus1.VALID), 32'h1);
      tick();
      chk("valid_one_clk", 32'(bus0.VALID), 32'h0);

      // Changes after the VALID cycle must not reach the wire.
      bus0.left_out = 16'hFFFF;
      bus1.left_out = 24'h000000;
      run_frame();
      chk("valid_period", 32'(bus0.VALID), 32'h1);
      chk("tx_left_i2s", cap0la, 32'h52E18000);
      chk("tx_left_i2s_late", cap0lb, 32'h52E18000);
      chk("tx_right_i2s", cap0r, 32'h00008000);
      chk("tx_left_lj24", cap1l, 32'h80000100);
      chk("tx_right_lj24", cap1r, 32'h40000200);
      chk("rx_left_i2s", 32'(bus0.left_in), 32'h0000A5C3);
      chk("rx_right_i2s", 32'(bus0.right_in), 32'h00000001);
      chk("rx_left_lj24", 32'(bus1.left_in), 32'h005A5A5A);
      chk("rx_right_lj24", 32'(bus1.right_in), 32'h00C30F81);

`ifdef CODEC_LOOPBACK_EN
      lpbk = 1'b1;
      tick();
      run_frame();
      chk("lpbk_left_i2s", cap0la, 32'h52E18000);
      lpbk = 1'b0;
`endif

      while ((e % 1024) != 700 && e < 20000) tick();
      chk("pre_rst_sclk", 32'(bus0.SCLK), 32'h1);
      chk("pre_rst_lrclk", 32'(bus0.LRCLK), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("midrst_outs0", 32'({bus0.MCLK, bus0.SCLK, bus0.LRCLK, bus0.RST_n, bus0.SD_in, bus0.VALID}), 32'h0);
      chk("midrst_left_in0", 32'(bus0.left_in), 32'h0);
      chk("midrst_right_in1", 32'(bus1.right_in), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      e = 0;
      while (bus0.VALID !== 1'b1 && e < 5000) tick();
      chk("restart_valid_clk", 32'(e), 32'd3071);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
